instr_encoder_loader: RTL and testbench

- Assembles MIPS instruction words from decoded field form (op class, op/func code, register addresses, shift amount, immediate/target) and streams them into instruction memory at consecutive word addresses.
- Used by the bench/boot path to load programs without a hex file.
- Produces exactly the bit layout the pipeline decoder splits apart: op[31:26], rs[25:21], rt[20:16], rd[15:11], sh_amt[10:6], func[5:0], imm[15:0], target[25:0].
- Contains an encode-request handshake, a small FIFO, a load state machine and an address counter.

---
 rtl/instr_encoder_loader.sv | 151 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Builds MIPS instruction words from decoded fields, buffers them in a small FIFO,
// and writes them to instruction memory at consecutive word addresses.
module instr_encoder_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h01000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_enc_valid,
  output logic        o_enc_ready,
  input  logic [1:0]  i_class_2,
  input  logic [5:0]  i_op_type_6,
  input  logic [4:0]  i_rs_addr_5,
  input  logic [4:0]  i_rt_addr_5,
  input  logic [4:0]  i_rd_addr_5,
  input  logic [4:0]  i_sh_amt_5,
  input  logic [15:0] i_imm_val_16,
  input  logic [25:0] i_target_26,
  input  logic        i_last,
  output logic [31:0] o_mem_addr_32,
  output logic [31:0] o_mem_data_32,
  output logic        o_mem_wr_valid,
  input  logic        i_mem_wr_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_count_16,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where i_enc_valid && o_enc_ready;
  // a memory write transfers where o_mem_wr_valid && i_mem_wr_ready. While valid is
  // high and the transfer has not happened, the presented payload does not change.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state;
  logic [31:0]    addr_q;
  logic [15:0]    count_q;
  logic           err_q;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  occ;
  logic           fifo_full;
  logic           fifo_empty;

  logic [31:0]    enc_word;
  logic           enc_legal;
  logic           accept;
  logic           push;
  logic           pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (i_class_2)
      2'd0: enc_word = {6'b000000, i_rs_addr_5, i_rt_addr_5, i_rd_addr_5,
                        i_sh_amt_5, i_op_type_6};
      2'd1: enc_word = {i_op_type_6, i_rs_addr_5, i_rt_addr_5, i_imm_val_16};
      2'd2: begin
        enc_word  = {i_op_type_6, i_target_26};
        // Only J and JAL exist in the jump class.
        enc_legal = (i_op_type_6 == 6'b000010) || (i_op_type_6 == 6'b000011);
      end
      default: enc_word = {6'b000001, i_rs_addr_5, i_op_type_6[4:0], i_imm_val_16};
    endcase
  end

  assign fifo_full   = (occ == CW'(FIFO_DEPTH));
  assign fifo_empty  = (occ == '0);
  assign o_enc_ready = (state == ACTIVE) && !fifo_full;
  assign accept      = i_enc_valid && o_enc_ready;
  assign push        = accept && enc_legal;
  assign pop         = o_mem_wr_valid && i_mem_wr_ready;

  // Payload is forced to zero whenever nothing is being offered.
  assign o_mem_wr_valid = !fifo_empty;
  assign o_mem_data_32  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
  assign o_mem_addr_32  = fifo_empty ? 32'h0 : addr_q;

  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);
  assign o_err      = err_q;
  assign o_count_16 = count_q;
  assign dbg_state  = state;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + 16'd1;
      end
      if (accept && !enc_legal) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= ACTIVE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (accept && i_last) state <= FLUSH;
        end
        FLUSH: begin
          // Empty occupancy means the final write already completed on an earlier edge.
          if (fifo_empty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, backpressure, invalid jumps,
// session completion and asynchronous reset in the middle of a flush.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clock;
  logic        reset;
  logic        i_start;
  logic        i_enc_valid;
  logic        o_enc_ready;
  logic [1:0]  i_class_2;
  logic [5:0]  i_op_type_6;
  logic [4:0]  i_rs_addr_5;
  logic [4:0]  i_rt_addr_5;
  logic [4:0]  i_rd_addr_5;
  logic [4:0]  i_sh_amt_5;
  logic [15:0] i_imm_val_16;
  logic [25:0] i_target_26;
  logic        i_last;
  logic [31:0] o_mem_addr_32;
  logic [31:0] o_mem_data_32;
  logic        o_mem_wr_valid;
  logic        i_mem_wr_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_count_16;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .i_start(i_start),
    .i_enc_valid(i_enc_valid), .o_enc_ready(o_enc_ready),
    .i_class_2(i_class_2), .i_op_type_6(i_op_type_6),
    .i_rs_addr_5(i_rs_addr_5), .i_rt_addr_5(i_rt_addr_5),
    .i_rd_addr_5(i_rd_addr_5), .i_sh_amt_5(i_sh_amt_5),
    .i_imm_val_16(i_imm_val_16), .i_target_26(i_target_26), .i_last(i_last),
    .o_mem_addr_32(o_mem_addr_32), .o_mem_data_32(o_mem_data_32),
    .o_mem_wr_valid(o_mem_wr_valid), .i_mem_wr_ready(i_mem_wr_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_count_16(o_count_16),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    i_enc_valid = 0; i_class_2 = 0; i_op_type_6 = 0; i_rs_addr_5 = 0; i_rt_addr_5 = 0;
    i_rd_addr_5 = 0; i_sh_amt_5 = 0; i_imm_val_16 = 0; i_target_26 = 0; i_last = 0;
  endtask

  task automatic set_req(input logic [1:0] cls, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    i_class_2 = cls; i_op_type_6 = op; i_rs_addr_5 = rs; i_rt_addr_5 = rt;
    i_rd_addr_5 = rd; i_sh_amt_5 = sh; i_imm_val_16 = imm; i_target_26 = tgt;
    i_last = last; i_enc_valid = 1;
  endtask

  task automatic start_session();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1; i_start = 0; i_mem_wr_ready = 0;
    clear_req();
    repeat (2) tick();
    checks++; if (o_enc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_enc_ready); end
    checks++; if (o_mem_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_mem_wr_valid); end
    checks++; if (o_mem_addr_32 !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_mem_addr_32); end
    checks++; if (o_mem_data_32 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_mem_data_32); end
    checks++; if ({o_busy, o_done, o_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {o_busy, o_done, o_err}); end
    checks++; if (o_count_16 !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", o_count_16); end
    reset = 0;
    tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_class0_single();
    i_mem_wr_ready = 1;
    start_session();
    checks++; if ({o_busy, o_enc_ready} !== 2'b11) begin errors++; $display("FAIL c0_active: got %b want 11", {o_busy, o_enc_ready}); end
    set_req(2'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    clear_req();
    checks++; if (o_mem_wr_valid !== 1'b1) begin errors++; $display("FAIL c0_valid: got %b want 1", o_mem_wr_valid); end
    checks++; if (o_mem_data_32 !== 32'h00221820) begin errors++; $display("FAIL c0_data: got %h want 00221820", o_mem_data_32); end
    checks++; if (o_mem_addr_32 !== BASE) begin errors++; $display("FAIL c0_addr: got %h want %h", o_mem_addr_32, BASE); end
    checks++; if (o_enc_ready !== 1'b0) begin errors++; $display("FAIL c0_flush_ready: got %b want 0", o_enc_ready); end
    tick();
    checks++; if ({o_mem_wr_valid, o_done} !== 2'b00) begin errors++; $display("FAIL c0_after_hs: got %b want 00", {o_mem_wr_valid, o_done}); end
    checks++; if (o_count_16 !== 16'd1) begin errors++; $display("FAIL c0_count: got %0d want 1", o_count_16); end
    tick();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL c0_done: got %b want 1", o_done); end
    tick();
    checks++; if ({o_done, o_busy} !== 2'b00) begin errors++; $display("FAIL c0_idle: got %b want 00", {o_done, o_busy}); end
  endtask

  task automatic test_class1_class2();
    i_mem_wr_ready = 1;
    start_session();
    set_req(2'd1, 6'b001001, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    tick();
    checks++; if (o_mem_data_32 !== 32'h2408FFFF) begin errors++; $display("FAIL c1_data: got %h want 2408ffff", o_mem_data_32); end
    set_req(2'd2, 6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1);
    tick();
    clear_req();
    checks++; if (o_mem_data_32 !== 32'h08100000) begin errors++; $display("FAIL c2_data: got %h want 08100000", o_mem_data_32); end
    checks++; if (o_mem_addr_32 !== 32'h01000004) begin errors++; $display("FAIL c2_addr: got %h want 01000004", o_mem_addr_32); end
    tick();
    checks++; if (o_count_16 !== 16'd2) begin errors++; $display("FAIL c2_count: got %0d want 2", o_count_16); end
    tick();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL c2_done: got %b want 1", o_done); end
    tick();
  endtask

  task automatic test_class3();
    i_mem_wr_ready = 1;
    start_session();
    set_req(2'd3, 6'b000001, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b0);
    tick();
    checks++; if (o_mem_data_32 !== 32'h04810003) begin errors++; $display("FAIL c3_data: got %h want 04810003", o_mem_data_32); end
    set_req(2'd3, 6'b100001, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b1);
    tick();
    clear_req();
    checks++; if (o_mem_data_32 !== 32'h04810003) begin errors++; $display("FAIL c3_bit5_data: got %h want 04810003", o_mem_data_32); end
    checks++; if (o_mem_addr_32 !== 32'h01000004) begin errors++; $display("FAIL c3_bit5_addr: got %h want 01000004", o_mem_addr_32); end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back_backpressure();
    int  k = 0;
    bit  done_seen = 0;
    bit  acc;
    i_mem_wr_ready = 0;
    start_session();
    for (int i = 0; i < 4; i++) begin
      set_req(2'd1, 6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0010 + 16'(i), 26'h0, 1'b0);
      tick();
    end
    checks++; if (o_enc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", o_enc_ready); end
    set_req(2'd1, 6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0014, 26'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (o_mem_data_32 !== 32'h20010010 || o_mem_addr_32 !== BASE || o_mem_wr_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold: got %h@%h v%b want 20010010@%h v1", o_mem_data_32, o_mem_addr_32, o_mem_wr_valid, BASE); end
    end
    i_mem_wr_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (o_done) done_seen = 1;
      if (done_seen) break;
      if (o_mem_wr_valid) begin
        checks++; if (o_mem_data_32 !== 32'h20010010 + 32'(k) || o_mem_addr_32 !== BASE + 32'(4 * k))
          begin errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", k, o_mem_data_32, o_mem_addr_32, 32'h20010010 + 32'(k), BASE + 32'(4 * k)); end
        k++;
      end
      acc = i_enc_valid && o_enc_ready;
      tick();
      if (acc) clear_req();
    end
    checks++; if (k !== 5) begin errors++; $display("FAIL bp_words: got %0d want 5", k); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done_seen); end
    checks++; if (o_count_16 !== 16'd5) begin errors++; $display("FAIL bp_count: got %0d want 5", o_count_16); end
    clear_req();
    repeat (2) tick();
  endtask

  task automatic test_invalid_jump();
    i_mem_wr_ready = 1;
    start_session();
    set_req(2'd2, 6'b000100, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000123, 1'b1);
    tick();
    clear_req();
    checks++; if ({o_err, o_mem_wr_valid, o_enc_ready} !== 3'b100) begin errors++; $display("FAIL inv_flags: got %b want 100", {o_err, o_mem_wr_valid, o_enc_ready}); end
    tick();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL inv_done: got %b want 1", o_done); end
    checks++; if (o_count_16 !== 16'd0) begin errors++; $display("FAIL inv_count: got %0d want 0", o_count_16); end
    tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL inv_sticky: got %b want 1", o_err); end
    start_session();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL inv_clear: got %b want 0", o_err); end
    set_req(2'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    clear_req();
    repeat (4) tick();
  endtask

  task automatic test_reset_in_flush();
    i_mem_wr_ready = 0;
    start_session();
    set_req(2'd1, 6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0100, 26'h0, 1'b0);
    tick();
    set_req(2'd1, 6'b001000, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0101, 26'h0, 1'b1);
    tick();
    clear_req();
    checks++; if (dbg_state !== 2'd2 || o_mem_wr_valid !== 1'b1) begin errors++; $display("FAIL rf_flush: got st%0d v%b want st2 v1", dbg_state, o_mem_wr_valid); end
    #2 reset = 1;
    #1;
    checks++; if ({o_mem_wr_valid, o_busy, o_enc_ready, o_done, o_err} !== 5'b0) begin errors++; $display("FAIL rf_async_flags: got %b want 00000", {o_mem_wr_valid, o_busy, o_enc_ready, o_done, o_err}); end
    checks++; if (o_mem_addr_32 !== 32'h0 || o_mem_data_32 !== 32'h0) begin errors++; $display("FAIL rf_async_bus: got %h@%h want 0@0", o_mem_data_32, o_mem_addr_32); end
    i_mem_wr_ready = 1;
    @(posedge clock);
    #3 reset = 0;
    repeat (2) tick();
    checks++; if (o_mem_wr_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rf_no_write: got v%b st%0d want v0 st0", o_mem_wr_valid, dbg_state); end
    start_session();
    set_req(2'd0, 6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    clear_req();
    checks++; if (o_mem_addr_32 !== BASE || o_mem_data_32 !== 32'h00221820) begin errors++; $display("FAIL rf_restart: got %h@%h want 00221820@%h", o_mem_data_32, o_mem_addr_32, BASE); end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_class0_single();
    test_class1_class2();
    test_class3();
    test_back_to_back_backpressure();
    test_invalid_jump();
    test_reset_in_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
